beat_tempo_generator: RTL and testbench
=======================================

BEAT_TEMPO_GENERATOR -- requirements
Module: beat_tempo_generator

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- CLK_HZ, 27000000, clk frequency in Hz.
- BPM_MIN, 40, lowest tempo.
- BPM_MAX, 240, highest tempo.
- BPM_RESET, 120, tempo after reset.
- BEATS, 8, beats per bar (1..15).
- DEBOUNCE_CYCLES, 270000, stable-input cycles required to accept a button level.

REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, input, 1, single system clock; all logic on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- btn_up, input, 1, raw asynchronous tempo-up button, active high.
- btn_down, input, 1, raw asynchronous tempo-down button, active high.
- btn_run, input, 1, raw asynchronous start/stop button, active high.
- beat_tick, output, 1, one-cycle pulse at each beat start.
- beat_num, output, 4, current beat index 1..BEATS, feeds the 7-segment stage.
- accent, output, 1, high for exactly the cycle in which beat_tick marks beat 1.
- bpm, output, 8, current tempo.
- running, output, 1, metronome active.

Function
REQ-003 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-004 Each button SHALL have an independent debounce counter.
- Debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any mismatch gap restarts the count.
REQ-005 A press event SHALL be a one-cycle pulse on a 0->1 transition of the debounced level; releases generate no event.
REQ-006 An up event SHALL set bpm <= bpm+1, saturating at BPM_MAX.
REQ-007 A down event SHALL set bpm <= bpm-1, saturating at BPM_MIN.
REQ-008 Up and down events in the same cycle SHALL leave bpm unchanged.
REQ-009 A run event SHALL toggle running.
REQ-010 The phase accumulator SHALL be 32 bits unsigned, with threshold T = CLK_HZ*60.
REQ-011 While running, each cycle:
- If acc+bpm >= T: acc <= acc+bpm-T and a beat is issued.
- Otherwise: acc <= acc+bpm.
REQ-012 A tempo change SHALL take effect on the accumulation in the cycle after bpm updates; the accumulator phase is not cleared.
REQ-013 On a running 0->1 transition:
- acc SHALL clear.
- beat_num SHALL be 1.
- beat_tick and accent SHALL assert in the cycle after running goes high (start beat).
REQ-014 Each accumulator-issued beat SHALL:
- pulse beat_tick for one cycle;
- advance beat_num by 1, wrapping BEATS -> 1;
- assert accent only when the new beat_num equals 1.
REQ-015 While stopped:
- acc SHALL hold 0.
- beat_tick and accent SHALL stay 0.
- beat_num SHALL hold its value.
- bpm SHALL remain adjustable.
REQ-016 A run event that stops the metronome in the same cycle as an accumulator overflow SHALL suppress that beat.
REQ-017 beat_tick, beat_num, accent, bpm and running SHALL all be registered outputs.
REQ-018 Minimum beat spacing SHALL be T/BPM_MAX cycles, and beat_tick SHALL never assert on consecutive cycles.

Reset
REQ-019 While rst_n=0, the block SHALL asynchronously force:
- bpm = BPM_RESET;
- running = 0;
- beat_num = 1;
- beat_tick = 0;
- accent = 0;
- acc = 0;
- all synchronizer, debounce and level registers = 0.
REQ-020 Reset asserted mid-beat SHALL discard accumulated phase; after release the block stays stopped until a run event.
REQ-021 The first clock edge after rst_n deasserts SHALL NOT generate a press event.

Verification
REQ-022 The bench SHALL cover these scenarios (CLK_HZ=100, DEBOUNCE_CYCLES=4, BEATS=8, so T=6000):
- Tick period: press run, bpm=120 -> start tick with beat_num=1 and accent=1, then ticks every 50 cycles; beat_num runs 2..8 then 1; accent is high only on beat 1.
- Debounce: btn_up glitches of 1-3 cycles -> bpm stays 120. A 6-cycle press -> bpm=121, with exactly one increment per press.
- Saturation: 130 up presses -> bpm=240, after which a tick occurs every 25 cycles. 210 down presses -> bpm=40. Simultaneous up+down -> bpm unchanged.
- Stop/start: stop mid-bar at beat_num=5 -> no ticks while stopped and beat_num holds 5. Restart -> immediate tick with beat_num=1 and accent=1.
- Reset mid-operation: pull rst_n low while running at beat 3 -> all outputs return to reset values immediately. After release, no ticks occur until a run press.
- Tempo change mid-beat: switch bpm from 120 to 60 at acc=3000 -> the next tick arrives (6000-3000)/60 = 50 cycles later, not 100.

Source files
------------

// File: rtl/beat_tempo_generator.sv
// Metronome core with debounced tempo/run buttons.
// A phase accumulator advances by bpm each cycle and issues a beat whenever
// it crosses CLK_HZ*60. This gives exactly bpm beats per minute with no divider.
module beat_tempo_generator #(
  parameter int unsigned CLK_HZ          = 27000000,
  parameter int unsigned BPM_MIN         = 40,
  parameter int unsigned BPM_MAX         = 240,
  parameter int unsigned BPM_RESET       = 120,
  parameter int unsigned BEATS           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_run,
  output logic       beat_tick,
  output logic [3:0] beat_num,
  output logic       accent,
  output logic [7:0] bpm,
  output logic       running
);

  localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [32:0] THRESH   = 33'(CLK_HZ * 60);
  localparam logic [7:0]  BPM_LO   = 8'(BPM_MIN);
  localparam logic [7:0]  BPM_HI   = 8'(BPM_MAX);
  localparam logic [7:0]  BPM_INIT = 8'(BPM_RESET);
  localparam logic [3:0]  BEAT_LAST = 4'(BEATS);

  // Button order inside vectors: 0 = up, 1 = down, 2 = run.
  logic [2:0] btn_raw;
  logic [2:0] press_evt;

  assign btn_raw = {btn_run, btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic          sync1_q, sync2_q;
      logic          level_q, level_d;
      logic          level_prev_q;
      logic [CW-1:0] cnt_q, cnt_d;

      // Debounce: flip the level only after CNT_LAST+1 consecutive mismatches.
      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
          if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Synchronizer, debounce counter and edge-detect history.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q      <= 1'b0;
          sync2_q      <= 1'b0;
          level_q      <= 1'b0;
          level_prev_q <= 1'b0;
          cnt_q        <= '0;
        end else begin
          sync1_q      <= btn_raw[gi];
          sync2_q      <= sync1_q;
          level_q      <= level_d;
          level_prev_q <= level_q;
          cnt_q        <= cnt_d;
        end
      end

      // Only the press edge is an event; a release is ignored.
      assign press_evt[gi] = level_q & ~level_prev_q;
    end
  endgenerate

  logic up_evt, down_evt, run_evt;
  assign up_evt   = press_evt[0];
  assign down_evt = press_evt[1];
  assign run_evt  = press_evt[2];

  logic [7:0]  bpm_q, bpm_d;
  logic        running_q, running_d;
  logic        start_q, start_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  num_q, num_d;
  logic        tick_q, tick_d;
  logic        accent_q, accent_d;
  logic [32:0] acc_sum;

  assign acc_sum = {1'b0, acc_q} + {25'd0, bpm_q};

  // Tempo adjust: saturating, and a simultaneous up+down cancels out.
  always_comb begin
    bpm_d = bpm_q;
    if (up_evt && !down_evt && bpm_q < BPM_HI) begin
      bpm_d = bpm_q + 8'd1;
    end else if (down_evt && !up_evt && bpm_q > BPM_LO) begin
      bpm_d = bpm_q - 8'd1;
    end
  end

  // Run/stop plus beat generation. start_q delays the start beat by one cycle.
  // Accumulation begins after that beat, so the first bar is full length.
  always_comb begin
    running_d = running_q ^ run_evt;
    start_d   = 1'b0;
    acc_d     = acc_q;
    num_d     = num_q;
    tick_d    = 1'b0;
    accent_d  = 1'b0;
    if (run_evt && !running_q) begin
      acc_d   = '0;
      num_d   = 4'd1;
      start_d = 1'b1;
    end else if (run_evt || !running_q) begin
      // Stopping (any overflow this cycle is dropped) or idle.
      acc_d = '0;
    end else if (start_q) begin
      acc_d    = '0;
      num_d    = 4'd1;
      tick_d   = 1'b1;
      accent_d = 1'b1;
    end else if (acc_sum >= THRESH) begin
      acc_d    = 32'(acc_sum - THRESH);
      tick_d   = 1'b1;
      num_d    = (num_q >= BEAT_LAST) ? 4'd1 : num_q + 4'd1;
      accent_d = (num_d == 4'd1);
    end else begin
      acc_d = acc_sum[31:0];
    end
  end

  // Core state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpm_q     <= BPM_INIT;
      running_q <= 1'b0;
      start_q   <= 1'b0;
      acc_q     <= '0;
      num_q     <= 4'd1;
      tick_q    <= 1'b0;
      accent_q  <= 1'b0;
    end else begin
      bpm_q     <= bpm_d;
      running_q <= running_d;
      start_q   <= start_d;
      acc_q     <= acc_d;
      num_q     <= num_d;
      tick_q    <= tick_d;
      accent_q  <= accent_d;
    end
  end

  assign beat_tick = tick_q;
  assign beat_num  = num_q;
  assign accent    = accent_q;
  assign bpm       = bpm_q;
  assign running   = running_q;

endmodule

// File: tb/tb_beat_tempo_generator.sv
// Directed bench for beat_tempo_generator at CLK_HZ=100, DEBOUNCE_CYCLES=4, BEATS=8 (T=6000).
// Button latency: a level driven just after edge e changes bpm/running at edge e+7.
module tb_beat_tempo_generator;

  logic       clk;
  logic       rst_n;
  logic       btn_up, btn_down, btn_run;
  logic       beat_tick;
  logic [3:0] beat_num;
  logic       accent;
  logic [7:0] bpm;
  logic       running;

  int checks;
  int failures;
  int n;

  beat_tempo_generator #(
    .CLK_HZ(100), .BPM_MIN(40), .BPM_MAX(240), .BPM_RESET(120),
    .BEATS(8), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_run(btn_run),
    .beat_tick(beat_tick), .beat_num(beat_num), .accent(accent),
    .bpm(bpm), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("ok   %s = %0d", tag, obs);
    end else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance edge by edge until beat_tick is seen; n = edges waited, -1 on timeout.
  task automatic wait_tick(input int max_cyc, output int nout);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (beat_tick !== 1'b1 && k < max_cyc);
    nout = (beat_tick === 1'b1) ? k : -1;
  endtask

  task automatic press(input logic up, input logic down, input logic run, input int hold);
    btn_up = up; btn_down = down; btn_run = run;
    repeat (hold) @(posedge clk);
    #1;
    btn_up = 1'b0; btn_down = 1'b0; btn_run = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bpm"},     32'(bpm), 120);
    check({tag, "_running"}, 32'(running), 0);
    check({tag, "_beatnum"}, 32'(beat_num), 1);
    check({tag, "_tick"},    32'(beat_tick), 0);
    check({tag, "_accent"},  32'(accent), 0);
  endtask

  initial begin
    int exp_num;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    wait_tick(100, n);
    check("idle_no_tick", n, -1);

    // Start at 120 bpm: start beat, then a beat every 6000/120 = 50 cycles.
    btn_run = 1'b1;
    wait_tick(30, n);
    btn_run = 1'b0;
    check("start_tick_seen", 32'(n > 0), 1);
    check("start_beatnum", 32'(beat_num), 1);
    check("start_accent", 32'(accent), 1);
    check("start_running", 32'(running), 1);
    @(posedge clk); #1;
    check("tick_single_cycle", 32'(beat_tick), 0);
    for (int i = 0; i < 8; i++) begin
      exp_num = (i == 7) ? 1 : i + 2;
      wait_tick(80, n);
      if (i == 0) n = n + 1;
      check($sformatf("period120_b%0d", i), n, 50);
      check($sformatf("beatnum_b%0d", i), 32'(beat_num), exp_num);
      check($sformatf("accent_b%0d", i), 32'(accent), (exp_num == 1) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      wait_tick(80, n);
      check($sformatf("beatnum_run_%0d", i), 32'(beat_num), i + 2);
    end

    // Stop at beat 5: no beats while stopped, beat_num holds.
    press(1'b0, 1'b0, 1'b1, 8);
    check("stop_running", 32'(running), 0);
    wait_tick(200, n);
    check("stopped_no_tick", n, -1);
    check("stopped_beatnum", 32'(beat_num), 5);

    // Debounce: short glitches ignored, each real press counts once.
    for (int g = 1; g <= 3; g++) begin
      press(1'b1, 1'b0, 1'b0, g);
      check($sformatf("glitch%0d_bpm", g), 32'(bpm), 120);
    end
    press(1'b1, 1'b0, 1'b0, 6);
    check("press6_bpm", 32'(bpm), 121);
    press(1'b1, 1'b0, 1'b0, 30);
    check("long_press_bpm", 32'(bpm), 122);
    press(1'b0, 1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 1'b0, 8);
    check("down2_bpm", 32'(bpm), 120);

    // Restart gives an immediate accented beat 1.
    btn_run = 1'b1;
    wait_tick(30, n);
    btn_run = 1'b0;
    check("restart_tick_seen", 32'(n > 0), 1);
    check("restart_beatnum", 32'(beat_num), 1);
    check("restart_accent", 32'(accent), 1);

    // Saturation high; at 240 bpm beats are 25 cycles apart.
    for (int i = 0; i < 130; i++) press(1'b1, 1'b0, 1'b0, 8);
    check("sat_max_bpm", 32'(bpm), 240);
    wait_tick(60, n);
    wait_tick(60, n);
    check("period240", n, 25);
    @(posedge clk); #1;
    check("tick240_single_cycle", 32'(beat_tick), 0);

    // Saturation low, then simultaneous up+down at 41.
    for (int i = 0; i < 210; i++) press(1'b0, 1'b1, 1'b0, 8);
    check("sat_min_bpm", 32'(bpm), 40);
    press(1'b1, 1'b0, 1'b0, 8);
    check("up_from_min_bpm", 32'(bpm), 41);
    press(1'b1, 1'b1, 1'b0, 8);
    check("up_down_same_bpm", 32'(bpm), 41);
    press(1'b0, 1'b1, 1'b0, 8);
    check("back_to_min_bpm", 32'(bpm), 40);

    // Tempo change mid-beat, phase kept: restart at 40 bpm (beat at s).
    // Up press driven after s+68 makes bpm 41 at s+75, when acc = 75*40 = 3000.
    // The remaining 3000 needs ceil(3000/41) = 74 edges -> beat at s+149.
    // Unchanged tempo would give 150, a cleared phase s+75+147.
    press(1'b0, 1'b0, 1'b1, 8);
    check("stop2_running", 32'(running), 0);
    btn_run = 1'b1;
    wait_tick(30, n);
    btn_run = 1'b0;
    check("restart2_beatnum", 32'(beat_num), 1);
    repeat (68) @(posedge clk);
    #1;
    btn_up = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    btn_up = 1'b0;
    wait_tick(200, n);
    check("tempo_change_spacing", (n < 0) ? n : n + 76, 149);
    check("tempo_change_bpm", 32'(bpm), 41);
    check("tempo_change_beatnum", 32'(beat_num), 2);

    // Reset mid-bar at beat 3: outputs return to reset values without a clock edge.
    wait_tick(200, n);
    check("pre_reset_beatnum", 32'(beat_num), 3);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    wait_tick(300, n);
    check("post_reset_no_tick", n, -1);
    check("post_reset_running", 32'(running), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
